// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between two writers:
//   req0 (pipeline writeback) and req1 (late load/memory return). Each writer
//   has a one-entry holding slot. One slot is granted per cycle and its write
//   is driven onto registered WEN/wsel/wdat. Slot1 is normally lower priority,
//   but it is forced through once it has been passed over MAX_WAIT cycles.
//   Writes to the same register leave in arrival order. Writes to register 0
//   are accepted and dropped.
//   pend_hit1/2 flag reads of a register that still has an outstanding write.
// Ports
//   CLK, nRST                  clock, synchronous active-low reset
//   req0_valid/ready/sel/dat   writeback request channel
//   req1_valid/ready/sel/dat   load-return request channel
//   WEN, wsel, wdat            registered register-file write port
//   rsel1, rsel2               read-select probes
//   pend_hit1, pend_hit2       probe hits a pending write (combinational)
module rf_write_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_sel,
   input  logic [DATA_W-1:0] req0_dat,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_sel,
   input  logic [DATA_W-1:0] req1_dat,
   output logic              WEN,
   output logic [ADDR_W-1:0] wsel,
   output logic [DATA_W-1:0] wdat,
   input  logic [ADDR_W-1:0] rsel1,
   input  logic [ADDR_W-1:0] rsel2,
   output logic              pend_hit1,
   output logic              pend_hit2
);

   localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic              slot0_valid_q, slot0_valid_d;
   logic [ADDR_W-1:0] slot0_sel_q, slot0_sel_d;
   logic [DATA_W-1:0] slot0_dat_q, slot0_dat_d;
   logic              slot1_valid_q, slot1_valid_d;
   logic [ADDR_W-1:0] slot1_sel_q, slot1_sel_d;
   logic [DATA_W-1:0] slot1_dat_q, slot1_dat_d;
   // Set when slot1 holds the older write (meaningful only while both are valid).
   logic              slot1_older_q, slot1_older_d;
   logic [WAIT_W-1:0] wait1_q, wait1_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] wsel_q, wsel_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;

   logic grant0, grant1;
   logic load0, load1;

   // Grant selection, from the held slots only.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (slot0_valid_q && slot1_valid_q) begin
         if (slot0_sel_q == slot1_sel_q) begin
            grant1 = slot1_older_q;
            grant0 = ~slot1_older_q;
         end else if (wait1_q == WAIT_MAX) begin
            grant1 = 1'b1;
         end else begin
            grant0 = 1'b1;
         end
      end else if (slot0_valid_q) begin
         grant0 = 1'b1;
      end else if (slot1_valid_q) begin
         grant1 = 1'b1;
      end
   end

   // A slot drained this cycle can be refilled on the same edge.
   assign req0_ready = ~slot0_valid_q | grant0;
   assign req1_ready = ~slot1_valid_q | grant1;

   // Register 0 is never written: accept the request but do not load it.
   assign load0 = req0_valid & req0_ready & (req0_sel != '0);
   assign load1 = req1_valid & req1_ready & (req1_sel != '0);

   always_comb begin
      slot0_valid_d = slot0_valid_q & ~grant0;
      slot0_sel_d   = slot0_sel_q;
      slot0_dat_d   = slot0_dat_q;
      slot1_valid_d = slot1_valid_q & ~grant1;
      slot1_sel_d   = slot1_sel_q;
      slot1_dat_d   = slot1_dat_q;
      slot1_older_d = slot1_older_q;
      if (load0) begin
         slot0_valid_d = 1'b1;
         slot0_sel_d   = req0_sel;
         slot0_dat_d   = req0_dat;
      end
      if (load1) begin
         slot1_valid_d = 1'b1;
         slot1_sel_d   = req1_sel;
         slot1_dat_d   = req1_dat;
      end
      // A fresh slot0 entry is younger than anything already in slot1; on a
      // simultaneous load, slot1 counts as older.
      if (load0) begin
         slot1_older_d = 1'b1;
      end else if (load1) begin
         slot1_older_d = 1'b0;
      end

      if (!slot1_valid_q || grant1) begin
         wait1_d = '0;
      end else if (wait1_q != WAIT_MAX) begin
         wait1_d = wait1_q + 1'b1;
      end else begin
         wait1_d = wait1_q;
      end

      wen_d  = grant0 | grant1;
      wsel_d = '0;
      wdat_d = '0;
      if (grant1) begin
         wsel_d = slot1_sel_q;
         wdat_d = slot1_dat_q;
      end else if (grant0) begin
         wsel_d = slot0_sel_q;
         wdat_d = slot0_dat_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         slot0_valid_q <= 1'b0;
         slot0_sel_q   <= '0;
         slot0_dat_q   <= '0;
         slot1_valid_q <= 1'b0;
         slot1_sel_q   <= '0;
         slot1_dat_q   <= '0;
         slot1_older_q <= 1'b0;
         wait1_q       <= '0;
         wen_q         <= 1'b0;
         wsel_q        <= '0;
         wdat_q        <= '0;
      end else begin
         slot0_valid_q <= slot0_valid_d;
         slot0_sel_q   <= slot0_sel_d;
         slot0_dat_q   <= slot0_dat_d;
         slot1_valid_q <= slot1_valid_d;
         slot1_sel_q   <= slot1_sel_d;
         slot1_dat_q   <= slot1_dat_d;
         slot1_older_q <= slot1_older_d;
         wait1_q       <= wait1_d;
         wen_q         <= wen_d;
         wsel_q        <= wsel_d;
         wdat_q        <= wdat_d;
      end
   end

   assign WEN  = wen_q;
   assign wsel = wsel_q;
   assign wdat = wdat_q;

   // A write is outstanding while held in a slot or on the output stage.
   assign pend_hit1 = (rsel1 != '0) &&
                      ((slot0_valid_q && slot0_sel_q == rsel1) ||
                       (slot1_valid_q && slot1_sel_q == rsel1) ||
                       (wen_q && wsel_q == rsel1));
   assign pend_hit2 = (rsel2 != '0) &&
                      ((slot0_valid_q && slot0_sel_q == rsel2) ||
                       (slot1_valid_q && slot1_sel_q == rsel2) ||
                       (wen_q && wsel_q == rsel2));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter. Expected writes are queued as each
// scenario is driven; every observed WEN pops and compares one entry.
module tb_rf_write_arbiter;

   logic        CLK;
   logic        nRST;
   logic        req0_valid, req0_ready;
   logic [4:0]  req0_sel;
   logic [31:0] req0_dat;
   logic        req1_valid, req1_ready;
   logic [4:0]  req1_sel;
   logic [31:0] req1_dat;
   logic        WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic [4:0]  rsel1, rsel2;
   logic        pend_hit1, pend_hit2;

   typedef struct packed {
      logic [4:0]  sel;
      logic [31:0] dat;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   rf_write_arbiter #(
      .DATA_W  (32),
      .ADDR_W  (5),
      .MAX_WAIT(3)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_sel  (req0_sel),
      .req0_dat  (req0_dat),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_sel  (req1_sel),
      .req1_dat  (req1_dat),
      .WEN       (WEN),
      .wsel      (wsel),
      .wdat      (wdat),
      .rsel1     (rsel1),
      .rsel2     (rsel2),
      .pend_hit1 (pend_hit1),
      .pend_hit2 (pend_hit2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic push(input logic [4:0] sel, input logic [31:0] dat);
      wr_t w;
      w.sel = sel;
      w.dat = dat;
      exp_q.push_back(w);
   endtask

   // Advance one clock; any write seen must be the next expected one.
   task automatic tick();
      wr_t want;
      logic have;
      @(posedge CLK);
      #1;
      if (WEN === 1'b1) begin
         have = (exp_q.size() != 0);
         want = '1;
         if (have) want = exp_q.pop_front();
         check("write", 64'({have, wsel, wdat}), 64'({1'b1, want.sel, want.dat}));
      end
   endtask

   initial begin
      int  i;
      int  cyc;
      logic r1, a0, a1;

      nRST       = 1'b0;
      req0_valid = 1'b1;
      req0_sel   = 5'd3;
      req0_dat   = 32'h1111;
      req1_valid = 1'b1;
      req1_sel   = 5'd4;
      req1_dat   = 32'h2222;
      rsel1      = 5'd0;
      rsel2      = 5'd0;

      // Reset held two edges with requests asserted.
      tick();
      tick();
      check("rst_wen", 64'(WEN), 64'(1'b0));
      check("rst_wsel", 64'(wsel), 64'(5'd0));
      check("rst_wdat", 64'(wdat), 64'(32'd0));
      check("rst_ready0", 64'(req0_ready), 64'(1'b1));
      check("rst_ready1", 64'(req1_ready), 64'(1'b1));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nRST       = 1'b1;
      tick();

      // Single write: accept edge t, WEN for one cycle after edge t+1.
      req0_valid = 1'b1;
      req0_sel   = 5'd5;
      req0_dat   = 32'hDEADBEEF;
      push(5'd5, 32'hDEADBEEF);
      tick();
      req0_valid = 1'b0;
      check("single_lat0", 64'(WEN), 64'(1'b0));
      tick();
      check("single_wen", 64'(WEN), 64'(1'b1));
      check("single_data", 64'({wsel, wdat}), 64'({5'd5, 32'hDEADBEEF}));
      tick();
      check("single_off", 64'(WEN), 64'(1'b0));

      // Contention: req1 sneaks in after exactly three req0 writes.
      for (int k = 1; k <= 3; k++) push(5'(k), 32'h100 + k);
      push(5'd9, 32'h9999);
      for (int k = 4; k <= 8; k++) push(5'(k), 32'h100 + k);
      i   = 0;
      r1  = 1'b1;
      cyc = 0;
      while ((i < 8 || r1) && cyc < 40) begin
         req0_valid = (i < 8);
         req0_sel   = 5'(i + 1);
         req0_dat   = 32'h101 + i;
         req1_valid = r1;
         req1_sel   = 5'd9;
         req1_dat   = 32'h9999;
         #1;
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         tick();
         if (a0) i++;
         if (a1) r1 = 1'b0;
         cyc++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("cont_accepted", 64'({i[3:0], r1}), 64'({4'd8, 1'b0}));
      tick();
      tick();
      tick();
      check("cont_drained", 64'(exp_q.size()), 64'(0));
      check("cont_wait1", 64'(dut.wait1_q), 64'(0));

      // Same register, slot0 accepted first: 0x1 then 0x2.
      push(5'd7, 32'h1);
      push(5'd7, 32'h2);
      req0_valid = 1'b1;
      req0_sel   = 5'd7;
      req0_dat   = 32'h1;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_sel   = 5'd7;
      req1_dat   = 32'h2;
      tick();
      req1_valid = 1'b0;
      check("order_a1", 64'({WEN, wdat}), 64'({1'b1, 32'h1}));
      tick();
      check("order_a2", 64'({WEN, wdat}), 64'({1'b1, 32'h2}));
      tick();
      check("order_a_end", 64'(WEN), 64'(1'b0));

      // Same register, accepted on the same edge: slot1 goes first.
      push(5'd7, 32'h2);
      push(5'd7, 32'h1);
      req0_valid = 1'b1;
      req0_sel   = 5'd7;
      req0_dat   = 32'h1;
      req1_valid = 1'b1;
      req1_sel   = 5'd7;
      req1_dat   = 32'h2;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      check("order_b1", 64'({WEN, wdat}), 64'({1'b1, 32'h2}));
      tick();
      check("order_b2", 64'({WEN, wdat}), 64'({1'b1, 32'h1}));
      tick();
      check("order_b_end", 64'(WEN), 64'(1'b0));

      // Register 0 is swallowed.
      req0_valid = 1'b1;
      req0_sel   = 5'd0;
      req0_dat   = 32'hBAD0;
      tick();
      req0_valid = 1'b0;
      tick();
      check("zero_nowen1", 64'(WEN), 64'(1'b0));
      tick();
      check("zero_nowen2", 64'(WEN), 64'(1'b0));
      check("zero_ready", 64'({req0_ready, req1_ready}), 64'(2'b11));

      // Hazard probe on register 12.
      rsel1 = 5'd12;
      rsel2 = 5'd0;
      #1;
      check("haz_before", 64'(pend_hit1), 64'(1'b0));
      push(5'd12, 32'hC);
      req1_valid = 1'b1;
      req1_sel   = 5'd12;
      req1_dat   = 32'hC;
      tick();
      req1_valid = 1'b0;
      #1;
      check("haz_slot", 64'({pend_hit1, pend_hit2}), 64'(2'b10));
      tick();
      check("haz_wen", 64'({WEN, pend_hit1, pend_hit2}), 64'(3'b110));
      tick();
      check("haz_clear", 64'({pend_hit1, pend_hit2}), 64'(2'b00));
      rsel1 = 5'd0;

      // Reset with both slots full discards the held writes.
      req0_valid = 1'b1;
      req0_sel   = 5'd3;
      req0_dat   = 32'h33;
      req1_valid = 1'b1;
      req1_sel   = 5'd4;
      req1_dat   = 32'h44;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nRST       = 1'b0;
      tick();
      nRST = 1'b1;
      check("midrst_wen", 64'(WEN), 64'(1'b0));
      check("midrst_ready", 64'({req0_ready, req1_ready}), 64'(2'b11));
      tick();
      check("midrst_wen1", 64'(WEN), 64'(1'b0));
      tick();
      check("midrst_wen2", 64'(WEN), 64'(1'b0));
      check("final_queue", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
